fetch_stage: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the fetch/decode pipeline register.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and assembles opcode+immediate pairs.
// It issues one IR word per cycle and handles stall, redirect and HLT.
module fetch_stage #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IMM_BIT    = 10,
  parameter logic [4:0]        HLT_OPCODE = 5'b00001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       ir_out,
  output logic [15:0]       imm_out,
  output logic              imm_valid,
  output logic [ADDR_W-1:0] pc_next_out,
  output logic              halted
);

  typedef enum logic [1:0] {S_FETCH, S_IMM, S_HALT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [15:0]       ir_hold_reg, ir_hold_next;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_hlt, is_two;

  assign pc_inc    = pc_reg + ADDR_W'(1);
  assign is_hlt    = (imem_data[15:11] == HLT_OPCODE);
  assign is_two    = imem_data[IMM_BIT];
  assign imem_addr = pc_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_hold_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_hold_reg <= ir_hold_next;
    end
  end

  // Redirect beats stall so a branch resolved during a hazard is never lost.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_hold_next = ir_hold_reg;
    if (redirect) begin
      pc_next      = redirect_pc;
      state_next   = S_FETCH;
      ir_hold_next = '0;
    end else if (!stall) begin
      case (state_reg)
        S_FETCH: begin
          if (is_hlt) begin
            state_next = S_HALT;
          end else if (is_two) begin
            ir_hold_next = imem_data;
            pc_next      = pc_inc;
            state_next   = S_IMM;
          end else begin
            pc_next = pc_inc;
          end
        end
        S_IMM: begin
          pc_next    = pc_inc;
          state_next = S_FETCH;
        end
        default: ;
      endcase
    end
  end

  // The opcode is held back one cycle so it reaches decode alongside its immediate.
  always_comb begin
    ir_out      = '0;
    imm_out     = '0;
    imm_valid   = 1'b0;
    halted      = 1'b0;
    pc_next_out = pc_inc;
    if (!reset) begin
      pc_next_out = RESET_PC;
    end else begin
      halted = (state_reg == S_HALT);
      if (!redirect) begin
        case (state_reg)
          S_FETCH: begin
            if (is_hlt || !is_two) ir_out = imem_data;
          end
          S_IMM: begin
            ir_out    = ir_hold_reg;
            imm_out   = imem_data;
            imm_valid = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/reset
// traffic, compared every cycle against an instruction-level reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr, imem_data, ir_out, imm_out, pc_next_out;
  logic        imm_valid, halted;

  logic [15:0] mem [0:65535];
  int checks = 0, failures = 0, cyc = 0;

  // reference model: PC, queue of an opcode waiting for its immediate, halt flag
  logic [15:0] m_pc = '0;
  logic [15:0] m_held[$];
  bit          m_halt = 1'b0;
  bit          m_known = 1'b0;

  logic [15:0] o_ir, o_imm, o_pn, o_addr;
  logic        o_iv, o_halt;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir_out(ir_out), .imm_out(imm_out), .imm_valid(imm_valid),
    .pc_next_out(pc_next_out), .halted(halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit rs, input bit st, input bit rd, input logic [15:0] rpc);
    logic [15:0] w, e_ir, e_imm, e_pn;
    logic        e_iv, e_halt;
    bit          pn_chk;
    @(negedge clk);
    reset = rs; stall = st; redirect = rd; redirect_pc = rpc;
    #1;
    o_ir = ir_out; o_imm = imm_out; o_iv = imm_valid; o_pn = pc_next_out;
    o_addr = imem_addr; o_halt = halted;
    w = mem[m_pc];
    e_ir = '0; e_imm = '0; e_iv = 1'b0; e_halt = 1'b0; pn_chk = 1'b0; e_pn = m_pc + 16'd1;
    if (!rs) begin
      e_pn = 16'h0000; pn_chk = 1'b1;
    end else begin
      e_halt = m_halt;
      if (!rd && !m_halt) begin
        if (m_held.size() != 0) begin
          e_ir = m_held[0]; e_imm = w; e_iv = 1'b1; pn_chk = 1'b1;
        end else if (w[15:11] == 5'b00001) begin
          e_ir = w;
        end else if (!w[10]) begin
          e_ir = w; pn_chk = 1'b1;
        end
      end
    end
    if (m_known || !rs) begin
      if (m_known) check_eq("imem_addr", 32'(o_addr), 32'(m_pc));
      check_eq("ir_out", 32'(o_ir), 32'(e_ir));
      check_eq("imm_out", 32'(o_imm), 32'(e_imm));
      check_eq("imm_valid", 32'(o_iv), 32'(e_iv));
      check_eq("halted", 32'(o_halt), 32'(e_halt));
      if (pn_chk) check_eq("pc_next_out", 32'(o_pn), 32'(e_pn));
    end
    if (o_ir != 16'h0000 || o_iv)
      $display("cyc=%0d addr=%h ir=%h imm=%h iv=%b halted=%b", cyc, o_addr, o_ir, o_imm, o_iv, o_halt);
    @(posedge clk);
    cyc++;
    if (!rs) begin
      m_pc = 16'h0000; m_held.delete(); m_halt = 1'b0; m_known = 1'b1;
    end else if (rd) begin
      m_pc = rpc; m_held.delete(); m_halt = 1'b0;
    end else if (!st && !m_halt) begin
      if (m_held.size() != 0) begin
        m_held.delete(); m_pc = m_pc + 16'd1;
      end else if (w[15:11] == 5'b00001) begin
        m_halt = 1'b1;
      end else if (w[10]) begin
        m_held.push_back(w); m_pc = m_pc + 16'd1;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'h1004;
    mem[4] = 16'h0400; mem[5] = 16'hBEEF; mem[6] = 16'h1006; mem[7] = 16'h0800;
    mem[16'h10] = 16'h0401; mem[16'h11] = 16'h1234;
    mem[16'h40] = 16'h0402; mem[16'h41] = 16'h5555;
    mem[16'hFFFF] = 16'h0403;

    // reset held two cycles
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("rst_addr", 32'(o_addr), 32'h0);
    check_eq("rst_ir", 32'(o_ir), 32'h0);
    check_eq("rst_halted", 32'(o_halt), 32'h0);

    // straight-line code
    step(1, 0, 0, 0); check_eq("sl_ir0", 32'(o_ir), 32'h1001); check_eq("sl_pn0", 32'(o_pn), 32'h1);
    step(1, 0, 0, 0); check_eq("sl_ir1", 32'(o_ir), 32'h1002); check_eq("sl_pn1", 32'(o_pn), 32'h2);
    step(1, 0, 0, 0); check_eq("sl_ir2", 32'(o_ir), 32'h1003); check_eq("sl_pn2", 32'(o_pn), 32'h3);
    step(1, 0, 0, 0); check_eq("sl_ir3", 32'(o_ir), 32'h1004);

    // two-word instruction: bubble, then stalled pair, then issued once
    step(1, 0, 0, 0); check_eq("tw_bubble", 32'(o_ir), 32'h0); check_eq("tw_bubble_iv", 32'(o_iv), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      check_eq("stl_addr", 32'(o_addr), 32'h5);
      check_eq("stl_ir", 32'(o_ir), 32'h0400);
      check_eq("stl_imm", 32'(o_imm), 32'hBEEF);
    end
    step(1, 0, 0, 0);
    check_eq("tw_ir", 32'(o_ir), 32'h0400); check_eq("tw_imm", 32'(o_imm), 32'hBEEF);
    check_eq("tw_iv", 32'(o_iv), 32'h1); check_eq("tw_pn", 32'(o_pn), 32'h6);
    step(1, 0, 0, 0); check_eq("nodup_ir", 32'(o_ir), 32'h1006); check_eq("nodup_iv", 32'(o_iv), 32'h0);

    // HLT at 7, frozen, then redirect out
    step(1, 0, 0, 0); check_eq("hlt_ir", 32'(o_ir), 32'h0800);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0);
      check_eq("hlt_addr", 32'(o_addr), 32'h7);
      check_eq("hlt_flag", 32'(o_halt), 32'h1);
      check_eq("hlt_nop", 32'(o_ir), 32'h0);
    end
    step(1, 0, 1, 16'h0010); check_eq("hlt_rd_nop", 32'(o_ir), 32'h0);
    step(1, 0, 0, 0);
    check_eq("resume_addr", 32'(o_addr), 32'h10); check_eq("resume_halted", 32'(o_halt), 32'h0);

    // redirect in S_IMM drops held word
    step(1, 0, 1, 16'h0040);
    check_eq("rd_imm_iv", 32'(o_iv), 32'h0); check_eq("rd_imm_ir", 32'(o_ir), 32'h0);
    step(1, 0, 0, 0); check_eq("rd_addr", 32'(o_addr), 32'h40);
    // redirect during stall in S_IMM
    step(1, 1, 1, 16'h0040); check_eq("rdst_iv", 32'(o_iv), 32'h0);
    step(1, 0, 0, 0);
    check_eq("rdst_addr", 32'(o_addr), 32'h40); check_eq("rdst_iv2", 32'(o_iv), 32'h0);

    // two-word instruction straddling the address wrap
    step(1, 0, 1, 16'hFFFF);
    step(1, 0, 0, 0); check_eq("wrap_bubble", 32'(o_addr), 32'hFFFF);
    step(1, 0, 0, 0);
    check_eq("wrap_addr", 32'(o_addr), 32'h0); check_eq("wrap_ir", 32'(o_ir), 32'h0403);
    check_eq("wrap_imm", 32'(o_imm), 32'h1001); check_eq("wrap_iv", 32'(o_iv), 32'h1);
    check_eq("wrap_pn", 32'(o_pn), 32'h1);

    // random traffic
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
